metronome_sequencer: RTL and testbench
======================================

# metronome_sequencer

Control and sequencing front end for the metronome tone path. It turns debounced button pulses into a saturating tempo value and starts and stops playback. It produces drift-free beat strobes from a phase accumulator, counts beats within a bar to flag the accent, and gates a fixed-length tone burst per beat. The downstream tone generator and tempo display consume `bpm`, `tone_en` and `tone_hi`.

## Interface
Parameters:
- `CLK_HZ`, 25000000, clock frequency; `60*CLK_HZ` must fit in 32 bits.
- `BPM_MIN`, 30, lower tempo limit.
- `BPM_MAX`, 250, upper tempo limit; must be ≤ 255.
- `BPM_RESET`, 60, tempo after reset.
- `TONE_CYCLES`, 2500000, tone burst length in clocks; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `btn_left`  in  1  one-cycle pulse: tempo −1.
- `btn_right`  in  1  one-cycle pulse: tempo +1.
- `btn_down`  in  1  one-cycle pulse: tempo −10.
- `btn_up`  in  1  one-cycle pulse: tempo +10.
- `btn_play`  in  1  one-cycle pulse: toggle run/stop.
- `beats_per_bar`  in  3  bar length 1..7; value 0 is treated as 1.
- `bpm`  out  8  current tempo.
- `running`  out  1  high in RUN.
- `beat`  out  1  one-cycle beat strobe.
- `accent`  out  1  qualifies `beat`; high on the first beat of a bar.
- `beat_idx`  out  3  index of the last beat issued, 0-based.
- `tone_en`  out  1  tone burst active.
- `tone_hi`  out  1  accent tone select; valid while `tone_en` is high.

## Operation
- Reset values:
  - `bpm` = `BPM_RESET`.
  - All other outputs 0.
  - Accumulator, tone counter and state cleared; state = IDLE.
- Tempo update, every cycle, in either state:
  - Priority is left (−1) > right (+1) > down (−10) > up (+10); only one button is applied per cycle.
  - The result saturates to [`BPM_MIN`, `BPM_MAX`].
  - Compute in 9+ bits signed; no wrap.
- State machine:
  - IDLE → RUN on `btn_play`.
  - RUN → IDLE on `btn_play`.
  - No other transitions.
- Entering RUN:
  - Accumulator := 0.
  - Issue beat 0 immediately: `beat`=1, `accent`=1, `beat_idx`=0.
- In RUN, each cycle, with `P` = `60*CLK_HZ` (32-bit constant):
  - If `acc + bpm ≥ P`: `acc := acc + bpm − P` and issue a beat.
  - Otherwise: `acc := acc + bpm`.
  - The sum is computed in 33 bits.
- On each non-initial beat:
  - Next index = `beat_idx + 1`; if it is ≥ `max(beats_per_bar,1)`, it becomes 0.
  - `accent` = (next index == 0).
  - `beats_per_bar` is sampled only at the beat, so changing it mid-bar takes effect at the next beat.
  - If the bar is shortened below the current index, the next beat wraps to 0.
- Tone:
  - Each beat loads the tone counter with `TONE_CYCLES`, sets `tone_en`=1, and latches `tone_hi` := `accent`.
  - The counter decrements each cycle; `tone_en` drops when it reaches 0.
  - A beat during an active burst restarts the burst with the new `tone_hi`.
- Entering IDLE, on the same edge as `btn_play` is sampled:
  - `running`, `beat`, `accent`, `tone_en` and `tone_hi` go to 0.
  - `beat_idx` and the accumulator are cleared.
  - `bpm` is kept.
- A tempo change while running takes effect on the next accumulate. There is no phase reset; the accumulator residue is kept.
- Simultaneous tempo button and `btn_play`: both are applied in the same cycle.

## Timing
- All outputs are registered.
- `btn_play` sampled at edge k (IDLE): `running`, `beat`, `accent` and `tone_en` are high in the cycle after edge k.
- `beat` is high for exactly one cycle.
- Beat interval at constant tempo averages `P/bpm` cycles with zero long-term drift. The interval is exact when `bpm` divides `P`.
- `tone_en` stays high for exactly `TONE_CYCLES` cycles after the beat edge, unless it is retriggered or stopped.
- Tempo button sampled at edge k: `bpm` shows the new value after edge k.
- `rst` asserted mid-run: all outputs take their reset values asynchronously; operation resumes in IDLE after deassertion.

## Test plan
1. Tempo saturation.
   - From reset (`bpm`=60), 4× `btn_down` → `bpm`=30 (20, then clamped to 30).
   - 25× `btn_up` → 250.
   - `btn_right` → 250.
   - `btn_left` → 249.
   - Same-cycle `btn_left`+`btn_up` → −1 only.
2. Beat timing.
   - Setup: `CLK_HZ`=1000, `bpm`=60, `beats_per_bar`=4.
   - `btn_play` → beat at cycle +1, then beats every 1000 cycles.
   - `beat_idx` sequence 0,1,2,3,0.
   - `accent` high only on index 0.
3. Fractional tempo.
   - Setup: `CLK_HZ`=1000, `bpm`=70 (P=60000).
   - Beat intervals are 857 or 858 cycles.
   - 70 beats span exactly 60000 cycles.
4. Tone bursts.
   - Setup: `TONE_CYCLES`=100.
   - Each beat → `tone_en` high exactly 100 cycles.
   - `tone_hi`=1 only on the accented beat.
   - With `TONE_CYCLES` > beat interval: `tone_en` stays continuously high and `tone_hi` follows the latest beat.
5. Stop and bar changes.
   - `btn_play` during a burst → next cycle `running`, `tone_en` and `beat_idx` = 0, with `bpm` unchanged.
   - Change `beats_per_bar` 4→2 at index 3 → next beat has index 0 with accent.
   - `beats_per_bar`=0 → every beat accented.
6. Asynchronous reset.
   - Assert `rst` between clock edges while running → outputs return to reset values immediately, and `bpm`=60.

Source files
------------

// File: rtl/metronome_sequencer_if.sv
// Button, bar-length and tone/tempo signals exchanged between the metronome
// sequencer and its surroundings.
interface metronome_sequencer_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_down;
    logic       btn_up;
    logic       btn_play;
    logic [2:0] beats_per_bar;
    logic [7:0] bpm;
    logic       running;
    logic       beat;
    logic       accent;
    logic [2:0] beat_idx;
    logic       tone_en;
    logic       tone_hi;

    modport master (
        output btn_left, btn_right, btn_down, btn_up, btn_play, beats_per_bar,
        input  bpm, running, beat, accent, beat_idx, tone_en, tone_hi
    );

    modport slave (
        input  btn_left, btn_right, btn_down, btn_up, btn_play, beats_per_bar,
        output bpm, running, beat, accent, beat_idx, tone_en, tone_hi
    );
endinterface

// File: rtl/metronome_sequencer.sv
// Metronome front end: saturating tempo from button pulses, run/stop FSM,
// phase-accumulator beat strobes with bar accent, and fixed-length tone bursts.
module metronome_sequencer #(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned BPM_MIN     = 30,
    parameter int unsigned BPM_MAX     = 250,
    parameter int unsigned BPM_RESET   = 60,
    parameter int unsigned TONE_CYCLES = 2500000
) (
    input logic                  clk,
    input logic                  rst,
    metronome_sequencer_if.slave bus
);

    // One beat is due each time the accumulator collects 60*CLK_HZ bpm-units.
    localparam logic [32:0]        PERIOD    = 33'(64'(CLK_HZ) * 64'd60);
    localparam int                 TW        = $clog2(TONE_CYCLES + 1);
    localparam logic [TW-1:0]      TONE_LOAD = TW'(TONE_CYCLES);
    localparam logic signed [9:0]  MIN_S     = 10'(BPM_MIN);
    localparam logic signed [9:0]  MAX_S     = 10'(BPM_MAX);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [7:0]      bpm_q, bpm_d;
    logic [31:0]     acc_q, acc_d;
    logic            beat_q, beat_d;
    logic            accent_q, accent_d;
    logic [2:0]      beat_idx_q, beat_idx_d;
    logic [TW-1:0]   tone_cnt_q, tone_cnt_d;
    logic            tone_en_q, tone_en_d;
    logic            tone_hi_q, tone_hi_d;

    logic signed [9:0] delta;
    logic signed [9:0] bpm_sum;
    logic [32:0]       acc_sum;
    logic [32:0]       acc_rem;
    logic [3:0]        idx_inc;
    logic [3:0]        bar_len;

    // Tempo: one button per cycle, evaluated signed so -10 near the floor cannot wrap.
    always_comb begin
        delta = 10'sd0;
        if (bus.btn_left)       delta = -10'sd1;
        else if (bus.btn_right) delta = 10'sd1;
        else if (bus.btn_down)  delta = -10'sd10;
        else if (bus.btn_up)    delta = 10'sd10;
        bpm_sum = $signed({2'b00, bpm_q}) + delta;
        if (bpm_sum < MIN_S)      bpm_d = 8'(BPM_MIN);
        else if (bpm_sum > MAX_S) bpm_d = 8'(BPM_MAX);
        else                      bpm_d = bpm_sum[7:0];
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_d     = 1'b0;
        accent_d   = 1'b0;
        beat_idx_d = beat_idx_q;
        tone_cnt_d = tone_cnt_q;
        tone_en_d  = tone_en_q;
        tone_hi_d  = tone_hi_q;

        acc_sum = {1'b0, acc_q} + {25'd0, bpm_q};
        acc_rem = acc_sum - PERIOD;
        idx_inc = {1'b0, beat_idx_q} + 4'd1;
        bar_len = (bus.beats_per_bar == 3'd0) ? 4'd1 : {1'b0, bus.beats_per_bar};

        unique case (state_q)
            IDLE: begin
                if (bus.btn_play) begin
                    state_d    = RUN;
                    acc_d      = '0;
                    beat_d     = 1'b1;
                    accent_d   = 1'b1;
                    beat_idx_d = 3'd0;
                end
            end
            RUN: begin
                if (bus.btn_play) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    beat_idx_d = 3'd0;
                end else if (acc_sum >= PERIOD) begin
                    acc_d  = acc_rem[31:0];
                    beat_d = 1'b1;
                    if (idx_inc >= bar_len) begin
                        beat_idx_d = 3'd0;
                        accent_d   = 1'b1;
                    end else begin
                        beat_idx_d = idx_inc[2:0];
                    end
                end else begin
                    acc_d = acc_sum[31:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Stopping wins over everything; a new beat restarts the burst.
        if (state_q == RUN && bus.btn_play) begin
            tone_cnt_d = '0;
            tone_en_d  = 1'b0;
            tone_hi_d  = 1'b0;
        end else if (beat_d) begin
            tone_cnt_d = TONE_LOAD;
            tone_en_d  = 1'b1;
            tone_hi_d  = accent_d;
        end else if (tone_cnt_q != '0) begin
            tone_cnt_d = tone_cnt_q - TW'(1);
            tone_en_d  = (tone_cnt_q != TW'(1));
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bpm_q      <= 8'(BPM_RESET);
            acc_q      <= '0;
            beat_q     <= 1'b0;
            accent_q   <= 1'b0;
            beat_idx_q <= 3'd0;
            tone_cnt_q <= '0;
            tone_en_q  <= 1'b0;
            tone_hi_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bpm_q      <= bpm_d;
            acc_q      <= acc_d;
            beat_q     <= beat_d;
            accent_q   <= accent_d;
            beat_idx_q <= beat_idx_d;
            tone_cnt_q <= tone_cnt_d;
            tone_en_q  <= tone_en_d;
            tone_hi_q  <= tone_hi_d;
        end
    end

    assign bus.bpm      = bpm_q;
    assign bus.running  = (state_q == RUN);
    assign bus.beat     = beat_q;
    assign bus.accent   = accent_q;
    assign bus.beat_idx = beat_idx_q;
    assign bus.tone_en  = tone_en_q;
    assign bus.tone_hi  = tone_hi_q;

endmodule

// File: tb/tb_metronome_sequencer.sv
// Directed plus randomized bench for metronome_sequencer, checked cycle by
// cycle against a plain-arithmetic model of the tempo, beat and tone rules.
module tb_metronome_sequencer;

    localparam int    CLK_HZ    = 1000;
    localparam int    BPM_MIN   = 30;
    localparam int    BPM_MAX   = 250;
    localparam int    BPM_RESET = 60;
    localparam int    TONE_A    = 100;
    localparam int    TONE_B    = 1500;
    localparam longint P        = 64'(60 * CLK_HZ);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    metronome_sequencer_if ifa ();
    metronome_sequencer_if ifb ();

    // The long-burst instance sees exactly the same stimulus.
    assign ifb.btn_left      = ifa.btn_left;
    assign ifb.btn_right     = ifa.btn_right;
    assign ifb.btn_down      = ifa.btn_down;
    assign ifb.btn_up        = ifa.btn_up;
    assign ifb.btn_play      = ifa.btn_play;
    assign ifb.beats_per_bar = ifa.beats_per_bar;

    metronome_sequencer #(
        .CLK_HZ(CLK_HZ), .BPM_MIN(BPM_MIN), .BPM_MAX(BPM_MAX),
        .BPM_RESET(BPM_RESET), .TONE_CYCLES(TONE_A)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    metronome_sequencer #(
        .CLK_HZ(CLK_HZ), .BPM_MIN(BPM_MIN), .BPM_MAX(BPM_MAX),
        .BPM_RESET(BPM_RESET), .TONE_CYCLES(TONE_B)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    bit     chk_en = 1'b0;
    longint last_press_edge = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: tempo as an integer, phase as elapsed bpm-units,
    // bursts as remaining-cycle counts.
    int     m_bpm = BPM_RESET;
    bit     m_run = 1'b0;
    bit     m_beat = 1'b0;
    bit     m_accent = 1'b0;
    int     m_idx = 0;
    longint m_acc = 0;
    int     m_rem_a = 0;
    int     m_rem_b = 0;
    bit     m_hi = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int nb;
        int bar;
        if (rst) begin
            m_bpm = BPM_RESET; m_run = 0; m_beat = 0; m_accent = 0; m_idx = 0;
            m_acc = 0; m_rem_a = 0; m_rem_b = 0; m_hi = 0;
        end else begin
            nb = m_bpm;
            if (ifa.btn_left)       nb = nb - 1;
            else if (ifa.btn_right) nb = nb + 1;
            else if (ifa.btn_down)  nb = nb - 10;
            else if (ifa.btn_up)    nb = nb + 10;
            if (nb < BPM_MIN) nb = BPM_MIN;
            if (nb > BPM_MAX) nb = BPM_MAX;
            m_beat = 0;
            m_accent = 0;
            if (ifa.btn_play) begin
                if (!m_run) begin
                    m_run = 1; m_acc = 0; m_idx = 0; m_beat = 1; m_accent = 1;
                end else begin
                    m_run = 0; m_acc = 0; m_idx = 0; m_rem_a = 0; m_rem_b = 0; m_hi = 0;
                end
            end else if (m_run) begin
                m_acc = m_acc + m_bpm;
                if (m_acc >= P) begin
                    m_acc = m_acc - P;
                    m_beat = 1;
                    bar = (ifa.beats_per_bar == 0) ? 1 : int'(ifa.beats_per_bar);
                    m_idx = m_idx + 1;
                    if (m_idx >= bar) m_idx = 0;
                    m_accent = (m_idx == 0);
                end
            end
            if (m_beat) begin
                m_rem_a = TONE_A; m_rem_b = TONE_B; m_hi = m_accent;
            end else begin
                if (m_rem_a > 0) m_rem_a--;
                if (m_rem_b > 0) m_rem_b--;
            end
            m_bpm = nb;
        end
    end

    always @(posedge clk) cyc++;

    // Beat log and burst-length log for the directed timing checks.
    longint beat_t[$];
    int     beat_i[$];
    bit     beat_acc[$];
    bit     beat_ha[$];
    bit     beat_hb[$];
    int     runs[$];
    int     run_len = 0;
    int     b_low = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("bpm", 32'(ifa.bpm), 32'(m_bpm));
            check("running", 32'(ifa.running), 32'(m_run));
            check("beat", 32'(ifa.beat), 32'(m_beat));
            if (m_beat) check("accent", 32'(ifa.accent), 32'(m_accent));
            check("beat_idx", 32'(ifa.beat_idx), 32'(m_idx));
            check("tone_en_a", 32'(ifa.tone_en), 32'(m_rem_a > 0));
            if (m_rem_a > 0) check("tone_hi_a", 32'(ifa.tone_hi), 32'(m_hi));
            check("tone_en_b", 32'(ifb.tone_en), 32'(m_rem_b > 0));
            if (m_rem_b > 0) check("tone_hi_b", 32'(ifb.tone_hi), 32'(m_hi));
            check("beat_b", 32'(ifb.beat), 32'(m_beat));
        end
        if (ifa.beat) begin
            beat_t.push_back(cyc);
            beat_i.push_back(int'(ifa.beat_idx));
            beat_acc.push_back(ifa.accent);
            beat_ha.push_back(ifa.tone_hi);
            beat_hb.push_back(ifb.tone_hi);
        end
        if (ifa.tone_en) run_len++;
        else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (ifa.running && !ifb.tone_en) b_low++;
    end

    task automatic press(input bit l, input bit r, input bit d, input bit u, input bit p);
        @(negedge clk);
        ifa.btn_left = l; ifa.btn_right = r; ifa.btn_down = d; ifa.btn_up = u; ifa.btn_play = p;
        last_press_edge = cyc + 1;
        @(negedge clk);
        ifa.btn_left = 0; ifa.btn_right = 0; ifa.btn_down = 0; ifa.btn_up = 0; ifa.btn_play = 0;
    endtask

    task automatic wait_beat(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifa.beat && n < budget);
        check({tag, "_arrived"}, 32'(ifa.beat), 32'd1);
    endtask

    task automatic clear_logs();
        beat_t.delete(); beat_i.delete(); beat_acc.delete();
        beat_ha.delete(); beat_hb.delete(); runs.delete();
        b_low = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bpm"}, 32'(ifa.bpm), 32'(BPM_RESET));
        check({tag, "_running"}, 32'(ifa.running), 32'd0);
        check({tag, "_beat"}, 32'(ifa.beat), 32'd0);
        check({tag, "_accent"}, 32'(ifa.accent), 32'd0);
        check({tag, "_idx"}, 32'(ifa.beat_idx), 32'd0);
        check({tag, "_tone_en"}, 32'(ifa.tone_en), 32'd0);
        check({tag, "_tone_hi"}, 32'(ifa.tone_hi), 32'd0);
    endtask

    initial begin
        int exp_idx[5];
        int bad;
        int n;
        exp_idx = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        ifa.btn_left = 0; ifa.btn_right = 0; ifa.btn_down = 0; ifa.btn_up = 0; ifa.btn_play = 0;
        ifa.beats_per_bar = 3'd4;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Tempo saturation
        repeat (4) press(0, 0, 1, 0, 0);
        check("sat_low", 32'(ifa.bpm), 32'd30);
        repeat (25) press(0, 0, 0, 1, 0);
        check("sat_high", 32'(ifa.bpm), 32'd250);
        press(0, 1, 0, 0, 0);
        check("right_at_max", 32'(ifa.bpm), 32'd250);
        press(1, 0, 0, 0, 0);
        check("left", 32'(ifa.bpm), 32'd249);
        press(1, 0, 0, 1, 0);
        check("left_beats_up", 32'(ifa.bpm), 32'd248);
        repeat (19) press(0, 0, 1, 0, 0);
        repeat (2) press(0, 1, 0, 0, 0);
        check("bpm_60", 32'(ifa.bpm), 32'd60);

        // Beat timing, bar indices, tone bursts at 60 bpm
        clear_logs();
        press(0, 0, 0, 0, 1);
        check("start_running", 32'(ifa.running), 32'd1);
        check("start_beat", 32'(ifa.beat), 32'd1);
        check("start_accent", 32'(ifa.accent), 32'd1);
        check("start_tone", 32'(ifa.tone_en), 32'd1);
        n = 0;
        while (beat_t.size() < 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("beats_seen", 32'(beat_t.size()), 32'd5);
        if (beat_t.size() >= 5) begin
            check("beat0_latency", 32'(beat_t[0] - last_press_edge), 32'd0);
            for (int i = 0; i < 5; i++) begin
                if (i > 0) check("beat_interval", 32'(beat_t[i] - beat_t[i-1]), 32'd1000);
                check("idx_seq", 32'(beat_i[i]), 32'(exp_idx[i]));
                check("accent_seq", 32'(beat_acc[i]), 32'(exp_idx[i] == 0));
                check("tone_hi_a_seq", 32'(beat_ha[i]), 32'(exp_idx[i] == 0));
                check("tone_hi_b_seq", 32'(beat_hb[i]), 32'(exp_idx[i] == 0));
            end
        end
        check("bursts_seen", 32'(runs.size()), 32'd4);
        for (int i = 0; i < runs.size(); i++) check("burst_len", 32'(runs[i]), 32'(TONE_A));
        check("long_burst_gapless", 32'(b_low), 32'd0);

        // Stop during a burst
        repeat (10) @(negedge clk);
        check("tone_before_stop", 32'(ifa.tone_en), 32'd1);
        press(0, 0, 0, 0, 1);
        check("stop_running", 32'(ifa.running), 32'd0);
        check("stop_tone_en", 32'(ifa.tone_en), 32'd0);
        check("stop_tone_hi", 32'(ifa.tone_hi), 32'd0);
        check("stop_tone_b", 32'(ifb.tone_en), 32'd0);
        check("stop_idx", 32'(ifa.beat_idx), 32'd0);
        check("stop_bpm", 32'(ifa.bpm), 32'd60);

        // Bar shortened at index 3, then bar length 0
        press(0, 0, 0, 0, 1);
        n = 0;
        while (ifa.beat_idx != 3'd3 && n < 4) begin
            wait_beat(1200, "to_idx3");
            n++;
        end
        check("reached_idx3", 32'(ifa.beat_idx), 32'd3);
        ifa.beats_per_bar = 3'd2;
        wait_beat(1200, "after_shrink");
        check("shrink_idx", 32'(ifa.beat_idx), 32'd0);
        check("shrink_accent", 32'(ifa.accent), 32'd1);
        wait_beat(1200, "bar2_second");
        check("bar2_idx", 32'(ifa.beat_idx), 32'd1);
        check("bar2_accent", 32'(ifa.accent), 32'd0);
        ifa.beats_per_bar = 3'd0;
        for (int i = 0; i < 3; i++) begin
            wait_beat(1200, "bar0");
            check("bar0_accent", 32'(ifa.accent), 32'd1);
            check("bar0_idx", 32'(ifa.beat_idx), 32'd0);
        end
        press(0, 0, 0, 0, 1);
        ifa.beats_per_bar = 3'd4;

        // Fractional tempo: 70 bpm
        press(0, 0, 0, 1, 0);
        check("bpm_70", 32'(ifa.bpm), 32'd70);
        repeat (TONE_B) @(negedge clk);
        clear_logs();
        press(0, 0, 0, 0, 1);
        n = 0;
        while (beat_t.size() < 71 && n < 62000) begin
            @(negedge clk);
            n++;
        end
        check("frac_beats_seen", 32'(beat_t.size()), 32'd71);
        if (beat_t.size() >= 71) begin
            bad = 0;
            for (int i = 1; i <= 70; i++) begin
                if (beat_t[i] - beat_t[i-1] != 857 && beat_t[i] - beat_t[i-1] != 858) bad++;
            end
            check("frac_bad_intervals", 32'(bad), 32'd0);
            check("frac_span", 32'(beat_t[70] - beat_t[0]), 32'd60000);
        end

        // Randomized buttons, bar lengths and play toggles against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ifa.btn_left  = ($urandom_range(39) == 0);
            ifa.btn_right = ($urandom_range(39) == 0);
            ifa.btn_down  = ($urandom_range(39) == 0);
            ifa.btn_up    = ($urandom_range(19) == 0);
            ifa.btn_play  = ($urandom_range(799) == 0);
            if ($urandom_range(299) == 0) ifa.beats_per_bar = 3'($urandom_range(7));
        end
        @(negedge clk);
        ifa.btn_left = 0; ifa.btn_right = 0; ifa.btn_down = 0; ifa.btn_up = 0; ifa.btn_play = 0;
        if (!ifa.running) press(0, 0, 0, 0, 1);
        repeat (20) @(negedge clk);
        check("pre_reset_running", 32'(ifa.running), 32'd1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_running", 32'(ifa.running), 32'd0);
        check("post_rst_bpm", 32'(ifa.bpm), 32'(BPM_RESET));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
